fifo_word_packer: RTL and testbench
===================================

FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning: idle cycles before a partial word is auto-flushed (range 2..255).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 fifo_empty  input  1  upstream fifo_mem empty flag.
REQ-005 fifo_data  input  8  upstream fifo_mem data_out, first-word-fall-through, valid whenever fifo_empty=0.
REQ-006 fifo_rd  output  1  read strobe to upstream fifo_mem rd, combinational.
REQ-007 flush  input  1  single-cycle request to emit the current partial word.
REQ-008 out_valid  output  1  out_data/out_keep hold a word.
REQ-009 out_ready  input  1  downstream accepts the word when out_valid=1.
REQ-010 out_data  output  32  packed word, first byte read in bits 7:0 (little-endian).
REQ-011 out_keep  output  4  byte-valid mask for out_data, bit n covers bits 8n+7:8n.

Function
REQ-012 Internal byte count cnt (0..4) and assembly register; a byte is accepted on a rising edge where fifo_rd=1.
REQ-013 fifo_rd = rst_n & ~fifo_empty & (~out_valid | out_ready); never asserted when fifo_empty=1.
REQ-014 Accepted byte is written to lane cnt of the assembly register, cnt increments by 1.
REQ-015 When the 4th byte is accepted, out_valid asserts next cycle with out_keep=4'b1111 and cnt returns to 0; no added latency.
REQ-016 Handoff: out_valid & out_ready in the same cycle as a byte accept -> word leaves, byte lands in lane 0 of the new word; sustained rate one byte per cycle.
REQ-017 out_valid & ~out_ready: out_data, out_keep, out_valid held stable; fifo_rd=0.
REQ-018 out_valid deasserts the cycle after out_ready=1 unless a new word completes the same edge.
REQ-019 flush with 1<=cnt<=3 (counting a byte accepted the same edge): word emitted next cycle, out_keep = (1<<cnt)-1, unused lanes zero, cnt=0.
REQ-020 flush with cnt=0 and no byte accepted that edge: ignored; flush that completes cnt=4: normal full word.
REQ-021 flush while out_valid=1 and out_ready=0: latched pending, executed on the edge the held word is accepted.
REQ-022 States: EMPTY (cnt=0), FILL (cnt 1..3), HOLD (out_valid=1, stalled); EMPTY->FILL on accept, FILL->EMPTY on 4th byte or flush with out_valid asserted, any->HOLD when out_valid=1 and out_ready=0.

Reset
REQ-023 rst_n=0 immediately forces out_valid=0, out_data=0, out_keep=0, fifo_rd=0, cnt=0, idle timer=0, pending flush cleared.
REQ-024 Reset mid-word discards partial bytes; first byte after release goes to lane 0.
REQ-025 No output toggles on the first clock edge after rst_n rises except in response to fifo_empty=0.

Configuration
REQ-026 Macro PACKER_TIMEOUT_EN defined: idle timer counts edges with cnt in 1..3, no accept, no flush; at TIMEOUT it acts as flush (REQ-019) and clears; any accept clears it.
REQ-027 Macro undefined: no timer logic, TIMEOUT unused, partial words leave only on flush.

Verification
REQ-028 Push bytes 0x01..0x08 into fifo_mem, out_ready=1 -> words 0x04030201 then 0x08070605, out_keep=4'hF, fifo_rd high on 8 consecutive cycles.
REQ-029 Bytes 0x11..0x14, out_ready=0 for 5 cycles -> out_data 0x14131211 stable, fifo_rd=0 with fifo_empty=0, resumes on out_ready=1, no byte lost.
REQ-030 Bytes 0xA1,0xA2 then flush -> out_data 0x0000A2A1, out_keep=4'b0011; flush with cnt=0 -> no word.
REQ-031 PACKER_TIMEOUT_EN, TIMEOUT=16, single byte 0x5A then fifo empty -> word 0x0000005A, out_keep=4'b0001 exactly 16 cycles after accept; without macro no word after 100 cycles.
REQ-032 rst_n pulsed low after 2 bytes -> outputs zero asynchronously; next bytes 0x31..0x34 -> 0x34333231.
REQ-033 17 bytes 0x01..0x11 through fifo_mem then flush -> 4 full words then 0x00000011 with out_keep=4'b0001; fifo_underflow never asserted.

Source files
------------

// File: rtl/fifo_word_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_word_packer : packs a FWFT byte stream into 32-bit little-endian words;
// idle auto-flush after TIMEOUT cycles when PACKER_TIMEOUT_EN is defined.
// Revision: 1.0
// ---------------------------------------------------------------------------
module fifo_word_packer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_keep
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  keep_q, keep_d;
  logic        pend_q, pend_d;

  logic        out_free;
  logic        accept;
  logic        flush_req;
  logic        emit;
  logic        timeout_hit;
  logic [2:0]  cnt_eff;
  logic [31:0] asm_eff;
  logic [4:0]  keep_wide;

`ifdef PACKER_TIMEOUT_EN
  logic [7:0]  timer_q, timer_d;
  logic        idle;
`endif

  // HOLD is exactly the "word presented" condition, so out_valid is a flop.
  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_keep  = keep_q;

  always_comb begin
    out_free = (state_q != HOLD) | out_ready;
    fifo_rd  = rst_n & ~fifo_empty & out_free;
    accept   = fifo_rd;

    asm_eff = asm_q;
    if (accept) begin
      asm_eff[{cnt_q[1:0], 3'b000} +: 8] = fifo_data;
    end
    cnt_eff = cnt_q + {2'b00, accept};

`ifdef PACKER_TIMEOUT_EN
    idle        = (cnt_q != 3'd0) & ~accept & ~flush & ~pend_q;
    timeout_hit = idle & (timer_q == 8'(TIMEOUT - 1));
    timer_d     = (idle & ~timeout_hit) ? timer_q + 8'd1 : 8'd0;
`else
    // TIMEOUT is only meaningful with the idle timer; this term is always 0.
    timeout_hit = 1'b0 & (TIMEOUT != 0);
`endif

    flush_req = flush | pend_q | timeout_hit;
    emit      = out_free & ((cnt_eff == 3'd4) | (flush_req & (cnt_eff != 3'd0)));
    pend_d    = flush_req & ~out_free;

    keep_wide = (5'd1 << cnt_eff) - 5'd1;

    cnt_d  = cnt_eff;
    asm_d  = asm_eff;
    data_d = data_q;
    keep_d = keep_q;
    if (emit) begin
      cnt_d  = 3'd0;
      asm_d  = 32'd0;
      data_d = asm_eff;
      keep_d = keep_wide[3:0];
    end

    if (emit || (state_q == HOLD && !out_ready)) begin
      state_d = HOLD;
    end else if (cnt_d != 3'd0) begin
      state_d = FILL;
    end else begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      cnt_q   <= 3'd0;
      asm_q   <= 32'd0;
      data_q  <= 32'd0;
      keep_q  <= 4'd0;
      pend_q  <= 1'b0;
`ifdef PACKER_TIMEOUT_EN
      timer_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      pend_q  <= pend_d;
`ifdef PACKER_TIMEOUT_EN
      timer_q <= timer_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_word_packer : table vectors plus directed stall/flush/reset sequences.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fifo_word_packer;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data  = 8'h00;
  logic        flush      = 1'b0;
  logic        out_ready  = 1'b0;
  logic        fifo_rd;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_keep;

  int n_checks   = 0;
  int n_pass     = 0;
  int underflows = 0;
  logic last_rd  = 1'b0;

  logic [7:0]  src_q[$];
  logic [31:0] got_data[$];
  logic [3:0]  got_keep[$];

  typedef struct {
    int          n;
    logic [31:0] bytes;
    logic        do_flush;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
  } vec_t;

  vec_t vecs[6];

  fifo_word_packer #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_keep   (out_keep)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic sync_fifo();
    fifo_empty = (src_q.size() == 0);
    if (fifo_empty) fifo_data = 8'h00;
    else fifo_data = src_q[0];
  endtask

  task automatic push_bytes(input int n, input logic [31:0] w);
    for (int i = 0; i < n; i++) src_q.push_back(w[8*i +: 8]);
    sync_fifo();
  endtask

  // One clock: sample handshakes before the edge, then update the FIFO model.
  task automatic cycle();
    logic rd;
    #1;
    rd = fifo_rd;
    last_rd = rd;
    if (rd && fifo_empty) underflows++;
    if (out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_keep.push_back(out_keep);
    end
    @(posedge clk);
    #1;
    if (rd && src_q.size() > 0) void'(src_q.pop_front());
    flush = 1'b0;
    sync_fifo();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && src_q.size() > 0; i++) cycle();
    check("drain", src_q.size(), 0);
  endtask

  task automatic clear_got();
    got_data.delete();
    got_keep.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int rd_cnt;
    int k;
    logic [31:0] exp_w;

    vecs[0] = '{4, 32'h04030201, 1'b0, 1'b1, 32'h04030201, 4'hF};
    vecs[1] = '{2, 32'h0000A2A1, 1'b1, 1'b1, 32'h0000A2A1, 4'h3};
    vecs[2] = '{0, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 4'h0};
    vecs[3] = '{1, 32'h0000005A, 1'b1, 1'b1, 32'h0000005A, 4'h1};
    vecs[4] = '{3, 32'h00CCBBAA, 1'b1, 1'b1, 32'h00CCBBAA, 4'h7};
    vecs[5] = '{4, 32'hDEADBEEF, 1'b1, 1'b1, 32'hDEADBEEF, 4'hF};

    // Reset state, with the upstream FIFO already non-empty
    push_bytes(1, 32'h99);
    repeat (2) cycle();
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst out_keep", out_keep, 0);
    check("rst fifo_rd", fifo_rd, 0);
    src_q.delete();
    sync_fifo();
    rst_n = 1'b1;
    repeat (3) cycle();
    check("post-rst idle valid", out_valid, 0);

    // Table vectors
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      clear_got();
      push_bytes(vecs[i].n, vecs[i].bytes);
      drain();
      if (vecs[i].do_flush) begin
        flush = 1'b1;
        cycle();
      end
      repeat (4) cycle();
      check($sformatf("vec%0d count", i), got_data.size(), vecs[i].exp_valid ? 1 : 0);
      if (vecs[i].exp_valid && got_data.size() > 0) begin
        check($sformatf("vec%0d data", i), got_data[0], vecs[i].exp_data);
        check($sformatf("vec%0d keep", i), got_keep[0], vecs[i].exp_keep);
      end
    end

    // Back-to-back words at one byte per cycle
    clear_got();
    push_bytes(4, 32'h04030201);
    push_bytes(4, 32'h08070605);
    rd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (last_rd) rd_cnt++;
    end
    check("stream rd cycles", rd_cnt, 8);
    repeat (4) cycle();
    check("stream count", got_data.size(), 2);
    if (got_data.size() == 2) begin
      check("stream w0", got_data[0], 32'h04030201);
      check("stream w1", got_data[1], 32'h08070605);
      check("stream keep", {got_keep[0], got_keep[1]}, 8'hFF);
    end

    // Back-pressure: word held stable, no reads
    clear_got();
    out_ready = 1'b0;
    push_bytes(4, 32'h14131211);
    push_bytes(4, 32'h18171615);
    repeat (4) cycle();
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("hold%0d data", i), out_data, 32'h14131211);
      check($sformatf("hold%0d rd/empty/valid", i), {fifo_rd, fifo_empty, out_valid}, 3'b001);
      cycle();
    end
    out_ready = 1'b1;
    repeat (8) cycle();
    check("stall count", got_data.size(), 2);
    if (got_data.size() == 2) begin
      check("stall w0", got_data[0], 32'h14131211);
      check("stall w1", got_data[1], 32'h18171615);
    end

    // Asynchronous reset while a word is held
    push_bytes(2, 32'h00002221);
    drain();
    out_ready = 1'b0;
    push_bytes(4, 32'h26252423);
    repeat (2) cycle();
    #1;
    check("pre-rst valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async rst valid", out_valid, 0);
    check("async rst data", out_data, 0);
    check("async rst keep", out_keep, 0);
    check("async rst rd", fifo_rd, 0);
    src_q.delete();
    sync_fifo();
    repeat (2) cycle();
    rst_n = 1'b1;

    // Reset mid-word discards the partial bytes
    out_ready = 1'b1;
    push_bytes(2, 32'h00004241);
    drain();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    clear_got();
    push_bytes(4, 32'h34333231);
    drain();
    repeat (3) cycle();
    check("post-rst count", got_data.size(), 1);
    if (got_data.size() == 1) begin
      check("post-rst word", got_data[0], 32'h34333231);
      check("post-rst keep", got_keep[0], 4'hF);
    end

    // Flush during a stall is executed on the accepting edge
    clear_got();
    out_ready = 1'b0;
    push_bytes(4, 32'h54535251);
    push_bytes(1, 32'h55);
    repeat (4) cycle();
    flush = 1'b1;
    cycle();
    cycle();
    out_ready = 1'b1;
    repeat (4) cycle();
    check("pend count", got_data.size(), 2);
    if (got_data.size() == 2) begin
      check("pend w0", got_data[0], 32'h54535251);
      check("pend w1", got_data[1], 32'h00000055);
      check("pend keep1", got_keep[1], 4'h1);
    end

    // 17 bytes then flush
    clear_got();
    for (int b = 1; b <= 17; b++) push_bytes(1, 32'(b));
    drain();
    flush = 1'b1;
    cycle();
    repeat (3) cycle();
    check("17B count", got_data.size(), 5);
    if (got_data.size() == 5) begin
      for (int w = 0; w < 4; w++) begin
        exp_w = {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)};
        check($sformatf("17B w%0d", w), got_data[w], exp_w);
        check($sformatf("17B keep%0d", w), got_keep[w], 4'hF);
      end
      check("17B tail", got_data[4], 32'h00000011);
      check("17B tail keep", got_keep[4], 4'h1);
    end

    // Idle auto-flush
    clear_got();
    push_bytes(1, 32'h5A);
    cycle();
`ifdef PACKER_TIMEOUT_EN
    k = 0;
    while (!out_valid && k < 40) begin
      cycle();
      k++;
    end
    check("timeout latency", k, 16);
    check("timeout data", out_data, 32'h0000005A);
    check("timeout keep", out_keep, 4'h1);
`else
    k = 0;
    repeat (100) cycle();
    check("no timeout count", got_data.size(), 0);
    check("no timeout valid", out_valid, 0);
    flush = 1'b1;
    cycle();
    repeat (2) cycle();
    check("late flush count", got_data.size(), 1);
    if (got_data.size() == 1) check("late flush data", got_data[0], 32'h0000005A);
`endif
    repeat (3) cycle();

    check("underflows", underflows, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
